// File: rtl/vec_chunk_buffer.sv
// Ping-pong activation buffer: scalar element stream in, WorkingRegs-wide chunks of a full vector out.
// Latency: write stored on its edge; out_data_ready 2 edges after the final write; chunk pointer moves in 1 edge.
// Backpressure: wr_ready low while the target bank is FULL/READING; writes then are dropped and set sticky overflow.
module vec_chunk_buffer #(
    parameter int VecLength   = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 12
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         wr_en,
    input  logic [NBits-1:0]             wr_data,
    output logic                         wr_ready,
    output logic                         overflow,
    input  logic                         rd_chunk_req,
    input  logic                         rd_ptr_rst,
    input  logic                         rd_done,
    output logic                         out_data_ready,
    output logic [WorkingRegs*NBits-1:0] rd_data
);
    localparam int NChunks = VecLength / WorkingRegs;
    localparam int CW      = (VecLength > 1) ? $clog2(VecLength) : 1;
    localparam int PW      = (NChunks > 1) ? $clog2(NChunks) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

    bank_state_t      state [2];
    logic [NBits-1:0] mem   [2][VecLength];
    logic             wr_bank;
    logic             rd_bank;
    logic [CW-1:0]    wr_cnt;
    logic [PW-1:0]    rd_ptr;

    logic wr_accept;
    logic wr_last;
    logic any_reading;
    logic promote;
    logic promote_bank;
    logic next_wr_bank;
    logic reading_next;

    always_comb begin
        wr_accept    = wr_en && wr_ready;
        wr_last      = wr_accept && (wr_cnt == CW'(VecLength - 1));
        next_wr_bank = wr_last ? ~wr_bank : wr_bank;
        any_reading  = (state[0] == READING) || (state[1] == READING);
        // The successor of rd_bank holds the older vector when both are FULL.
        promote_bank = (state[~rd_bank] == FULL) ? ~rd_bank : rd_bank;
        promote      = !any_reading && (state[promote_bank] == FULL);
        reading_next = (any_reading && !rd_done) || promote;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= EMPTY;
                for (int i = 0; i < VecLength; i++) begin
                    mem[b][i] <= '0;
                end
            end
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_cnt         <= '0;
            rd_ptr         <= '0;
            wr_ready       <= 1'b1;
            overflow       <= 1'b0;
            out_data_ready <= 1'b0;
        end else begin
            if (wr_accept) begin
                mem[wr_bank][wr_cnt] <= wr_data;
                if (wr_last) begin
                    state[wr_bank] <= FULL;
                    wr_cnt         <= '0;
                end else begin
                    state[wr_bank] <= FILLING;
                    wr_cnt         <= wr_cnt + 1'b1;
                end
            end
            wr_bank <= next_wr_bank;
            if (wr_en && !wr_ready) begin
                overflow <= 1'b1;
            end
            // Looks at the pre-edge state, so a bank freed by rd_done opens one edge later.
            wr_ready <= (state[next_wr_bank] == EMPTY) || (state[next_wr_bank] == FILLING);

            if (rd_done && any_reading) begin
                state[rd_bank] <= EMPTY;
            end
            if (promote) begin
                state[promote_bank] <= READING;
                rd_bank             <= promote_bank;
                rd_ptr              <= '0;
            end else if (rd_ptr_rst) begin
                rd_ptr <= '0;
            end else if (rd_chunk_req) begin
                rd_ptr <= (rd_ptr == PW'(NChunks - 1)) ? '0 : rd_ptr + 1'b1;
            end
            out_data_ready <= reading_next;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            rd_data[i*NBits +: NBits] = mem[rd_bank][CW'(rd_ptr) * CW'(WorkingRegs) + CW'(i)];
        end
    end

endmodule

// File: tb/tb_vec_chunk_buffer.sv
// Bench for vec_chunk_buffer: directed scenarios plus randomized traffic against a vector-queue model.
module tb_vec_chunk_buffer;
    localparam int VL = 8;
    localparam int WR = 4;
    localparam int NB = 12;
    localparam int NC = VL / WR;

    typedef logic [VL*NB-1:0] vec_t;
    typedef logic [WR*NB-1:0] chunk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [NB-1:0] wr_data = '0;
    logic          wr_ready;
    logic          overflow;
    logic          rd_chunk_req = 1'b0;
    logic          rd_ptr_rst = 1'b0;
    logic          rd_done = 1'b0;
    logic          out_data_ready;
    chunk_t        rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    vec_chunk_buffer #(.VecLength(VL), .WorkingRegs(WR), .NBits(NB)) dut (
        .clk_in(clk), .rst_in(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .overflow(overflow), .rd_chunk_req(rd_chunk_req),
        .rd_ptr_rst(rd_ptr_rst), .rd_done(rd_done), .out_data_ready(out_data_ready),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic chunk_t chunk_of(input vec_t v, input int p);
        return v[p*WR*NB +: WR*NB];
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < VL; k++) v[k*NB +: NB] = NB'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input vec_t v);
        for (int k = 0; k < VL; k++) begin
            wr_en = 1'b1;
            wr_data = v[k*NB +: NB];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_req(input logic req, input logic prst);
        rd_chunk_req = req;
        rd_ptr_rst = prst;
        tick();
        rd_chunk_req = 1'b0;
        rd_ptr_rst = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready: got %b want 0", out_data_ready); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    vec_t vec_a;

    task automatic test_fill_serve();
        for (int k = 0; k < VL; k++) vec_a[k*NB +: NB] = NB'(k + 1);
        write_vec(vec_a);
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_early: got %b want 0", out_data_ready); end
        tick();
        n_checks++; if (out_data_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b want 1", out_data_ready); end
        n_checks++; if (rd_data !== chunk_of(vec_a, 0)) begin n_fail++; $display("FAIL fill_chunk0: got %h want %h", rd_data, chunk_of(vec_a, 0)); end
        pulse_req(1'b1, 1'b0);
        n_checks++; if (rd_data !== chunk_of(vec_a, 1)) begin n_fail++; $display("FAIL fill_chunk1: got %h want %h", rd_data, chunk_of(vec_a, 1)); end
        pulse_req(1'b1, 1'b0);
        n_checks++; if (rd_data !== chunk_of(vec_a, 0)) begin n_fail++; $display("FAIL fill_wrap: got %h want %h", rd_data, chunk_of(vec_a, 0)); end
    endtask

    task automatic test_replay();
        pulse_req(1'b1, 1'b0);
        pulse_req(1'b1, 1'b1);
        n_checks++; if (rd_data !== chunk_of(vec_a, 0)) begin n_fail++; $display("FAIL replay_rst_prio: got %h want %h", rd_data, chunk_of(vec_a, 0)); end
        for (int r = 0; r < 8; r++) begin
            n_checks++; if (rd_data !== chunk_of(vec_a, 0)) begin n_fail++; $display("FAIL replay_c0 r%0d: got %h want %h", r, rd_data, chunk_of(vec_a, 0)); end
            pulse_req(1'b1, 1'b0);
            n_checks++; if (rd_data !== chunk_of(vec_a, 1)) begin n_fail++; $display("FAIL replay_c1 r%0d: got %h want %h", r, rd_data, chunk_of(vec_a, 1)); end
            pulse_req(1'b0, 1'b1);
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL replay_done: got %b want 0", out_data_ready); end
        tick();
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL replay_idle: got %b want 0", out_data_ready); end
    endtask

    task automatic test_ping_pong_overflow();
        vec_t a, b, c;
        a = rand_vec();
        b = rand_vec();
        c = rand_vec();
        write_vec(a);
        tick();
        n_checks++; if (rd_data !== chunk_of(a, 0)) begin n_fail++; $display("FAIL pp_a0: got %h want %h", rd_data, chunk_of(a, 0)); end
        write_vec(b);
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL pp_wr_ready_full: got %b want 0", wr_ready); end
        n_checks++; if (rd_data !== chunk_of(a, 0)) begin n_fail++; $display("FAIL pp_a0_hold: got %h want %h", rd_data, chunk_of(a, 0)); end
        wr_en = 1'b1;
        wr_data = 12'h7FF;
        tick();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL pp_gap: got %b want 0", out_data_ready); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL pp_wr_ready_1edge: got %b want 0", wr_ready); end
        tick();
        n_checks++; if (out_data_ready !== 1'b1) begin n_fail++; $display("FAIL pp_b_ready: got %b want 1", out_data_ready); end
        n_checks++; if (rd_data !== chunk_of(b, 0)) begin n_fail++; $display("FAIL pp_b0: got %h want %h", rd_data, chunk_of(b, 0)); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL pp_wr_ready_2edge: got %b want 1", wr_ready); end
        write_vec(c);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        n_checks++; if (rd_data !== chunk_of(c, 0)) begin n_fail++; $display("FAIL ovf_not_stored c0: got %h want %h", rd_data, chunk_of(c, 0)); end
        pulse_req(1'b1, 1'b0);
        n_checks++; if (rd_data !== chunk_of(c, 1)) begin n_fail++; $display("FAIL ovf_c1: got %h want %h", rd_data, chunk_of(c, 1)); end
    endtask

    task automatic test_simultaneous();
        vec_t d, e;
        d = rand_vec();
        e = rand_vec();
        for (int k = 0; k < VL - 1; k++) begin
            wr_en = 1'b1;
            wr_data = d[k*NB +: NB];
            tick();
        end
        wr_data = d[(VL-1)*NB +: NB];
        rd_done = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_done = 1'b0;
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL sim_gap: got %b want 0", out_data_ready); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL sim_wr_ready_low: got %b want 0", wr_ready); end
        tick();
        n_checks++; if (out_data_ready !== 1'b1) begin n_fail++; $display("FAIL sim_d_ready: got %b want 1", out_data_ready); end
        n_checks++; if (rd_data !== chunk_of(d, 0)) begin n_fail++; $display("FAIL sim_d0: got %h want %h", rd_data, chunk_of(d, 0)); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sim_wr_ready_high: got %b want 1", wr_ready); end
        write_vec(e);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        n_checks++; if (rd_data !== chunk_of(e, 0)) begin n_fail++; $display("FAIL sim_e0: got %h want %h", rd_data, chunk_of(e, 0)); end
    endtask

    task automatic test_async_reset();
        vec_t f;
        f = rand_vec();
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1;
            wr_data = NB'($urandom);
            tick();
        end
        wr_en = 1'b0;
        pulse_req(1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ar_ovf_sticky: got %b want 1", overflow); end
        #1 rst_n = 1'b0;
        #3;
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL ar_out_ready: got %b want 0", out_data_ready); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ar_wr_ready: got %b want 1", wr_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ar_overflow: got %b want 0", overflow); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL ar_rd_data: got %h want 0", rd_data); end
        #2 rst_n = 1'b1;
        tick();
        write_vec(f);
        n_checks++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL ar_fill_early: got %b want 0", out_data_ready); end
        tick();
        n_checks++; if (rd_data !== chunk_of(f, 0) || out_data_ready !== 1'b1) begin n_fail++; $display("FAIL ar_f0: got %h/%b want %h/1", rd_data, out_data_ready, chunk_of(f, 0)); end
        pulse_req(1'b1, 1'b0);
        n_checks++; if (rd_data !== chunk_of(f, 1)) begin n_fail++; $display("FAIL ar_f1: got %h want %h", rd_data, chunk_of(f, 1)); end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
    endtask

    task automatic test_random();
        localparam int NV = 12;
        vec_t q[$];
        vec_t fill;
        int   fcnt = 0;
        int   written = 0;
        int   served = 0;
        int   mptr = 0;
        int   r;
        logic prev_out = 1'b0;
        fill = '0;
        for (int cyc = 0; cyc < 3000 && served < NV; cyc++) begin
            rd_chunk_req = 1'b0;
            rd_ptr_rst = 1'b0;
            rd_done = 1'b0;
            if (out_data_ready) begin
                if (!prev_out) mptr = 0;
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_spurious_ready: got ready with no vector pending");
                end else begin
                    n_checks++; if (rd_data !== chunk_of(q[0], mptr)) begin n_fail++; $display("FAIL rand_chunk v%0d p%0d: got %h want %h", served, mptr, rd_data, chunk_of(q[0], mptr)); end
                    r = $urandom_range(0, 9);
                    if (r < 4) begin rd_chunk_req = 1'b1; mptr = (mptr + 1) % NC; end
                    else if (r == 4) begin rd_ptr_rst = 1'b1; mptr = 0; end
                    else if (r == 5) begin rd_ptr_rst = 1'b1; rd_chunk_req = 1'b1; mptr = 0; end
                    else if (r == 6) begin rd_done = 1'b1; void'(q.pop_front()); served++; end
                end
            end
            prev_out = out_data_ready;
            wr_en = (written < NV) && wr_ready && ($urandom_range(0, 3) != 0);
            wr_data = NB'($urandom);
            if (wr_en) begin
                fill[fcnt*NB +: NB] = wr_data;
                fcnt++;
                if (fcnt == VL) begin
                    q.push_back(fill);
                    fcnt = 0;
                    written++;
                end
            end
            tick();
        end
        wr_en = 1'b0;
        rd_chunk_req = 1'b0;
        rd_ptr_rst = 1'b0;
        rd_done = 1'b0;
        n_checks++; if (served != NV) begin n_fail++; $display("FAIL rand_served: got %0d want %0d", served, NV); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_fill_serve();
        test_replay();
        test_ping_pong_overflow();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
